crc16_engine: RTL

Multi-cycle CRC-16 calculator that sits directly beside the frame parser. It consumes the parser's 128-bit payload window (data_to_crc) under the crc16_valid request. It returns the computed checksum on data_from_crc, qualified by the level-high crc16_ready. The parser compares this checksum against the CRC field extracted from the frame and gates its FIFO write on the result.

---
 rtl/crc16_pkg.sv | 35 +++
 rtl/crc16_engine_step.sv | 23 ++
 rtl/crc16_engine.sv | 113 +++++++++++
 3 files changed

// File: rtl/crc16_pkg.sv
// Shared constants, FSM state type and the reference bit-serial CRC-16 fold
// used by the CRC engine and its single-step datapath.
package crc16_pkg;

   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
   localparam logic [15:0] CRC16_XOR_OUT = 16'h0000;
   localparam int          CRC_BLOCK_W   = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } crc_state_t;

   // Folds the top nbits of 'bits' (bit CRC_BLOCK_W-1 first) into crc, one bit at a time.
   function automatic logic [15:0] crc16_fold(
      input logic [15:0]            crc,
      input logic [CRC_BLOCK_W-1:0] bits,
      input int                     nbits,
      input logic [15:0]            poly = CRC16_POLY
   );
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 0; i < CRC_BLOCK_W; i++) begin
         if (i < nbits) begin
            fb = c[15] ^ bits[CRC_BLOCK_W-1-i];
            c  = {c[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/crc16_engine_step.sv
// One parallel CRC fold: absorbs BITS_PER_CYCLE data bits (MSB first) into the
// running CRC in a single combinational step.
module crc16_step
   import crc16_pkg::*;
#(
   parameter logic [15:0] POLY           = CRC16_POLY,
   parameter int          BITS_PER_CYCLE = 8
) (
   input  logic [15:0]               crc_in,
   input  logic [BITS_PER_CYCLE-1:0] data_in,
   output logic [15:0]               crc_out
);

   logic [CRC_BLOCK_W-1:0] aligned;

   // Left-align the chunk so the fold consumes data_in MSB first.
   always_comb begin
      aligned = '0;
      aligned[CRC_BLOCK_W-1 -: BITS_PER_CYCLE] = data_in;
      crc_out = crc16_fold(crc_in, aligned, BITS_PER_CYCLE, POLY);
   end

endmodule

// File: rtl/crc16_engine.sv
// Multi-cycle CRC-16 engine: snapshots a 128-bit block on request, folds it
// BITS_PER_CYCLE bits per cycle and holds the result until the request drops.
module crc16_engine
   import crc16_pkg::*;
#(
   parameter logic [15:0] POLY           = CRC16_POLY,
   parameter logic [15:0] INIT           = CRC16_INIT,
   parameter logic [15:0] XOR_OUT        = CRC16_XOR_OUT,
   parameter int          BITS_PER_CYCLE = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_n,
   input  logic [CRC_BLOCK_W-1:0] data_to_crc,
   input  logic                   crc16_valid,
   output logic [15:0]            data_from_crc,
   output logic                   crc16_ready
);

   localparam int N     = CRC_BLOCK_W / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   generate
      if (!(BITS_PER_CYCLE == 1  || BITS_PER_CYCLE == 2  || BITS_PER_CYCLE == 4  ||
            BITS_PER_CYCLE == 8  || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32 ||
            BITS_PER_CYCLE == 64 || BITS_PER_CYCLE == 128)) begin : g_bad_bpc
         $error("crc16_engine: BITS_PER_CYCLE must be a power of two from 1 to 128");
      end
   endgenerate

   crc_state_t             state_q, state_d;
   logic [15:0]            crc_q, crc_d;
   logic [CRC_BLOCK_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ready_q, ready_d;
   logic [15:0]            dout_q, dout_d;
   logic [15:0]            step_crc;

   crc16_step #(
      .POLY           (POLY),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .crc_in  (crc_q),
      .data_in (shift_q[CRC_BLOCK_W-1 -: BITS_PER_CYCLE]),
      .crc_out (step_crc)
   );

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      dout_d  = dout_q;
      case (state_q)
         IDLE: begin
            if (crc16_valid) begin
               shift_d = data_to_crc;
               crc_d   = INIT;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            // A dropped request abandons the job; the previous result stays on the port.
            if (!crc16_valid) begin
               state_d = IDLE;
            end else begin
               crc_d   = step_crc;
               shift_d = shift_q << BITS_PER_CYCLE;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  dout_d  = step_crc ^ XOR_OUT;
                  ready_d = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (!crc16_valid) begin
               ready_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            ready_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         crc_q   <= INIT;
         shift_q <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         dout_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         dout_q  <= dout_d;
      end
   end

   assign data_from_crc = dout_q;
   assign crc16_ready   = ready_q;

endmodule
